// File: rtl/cabac_pkg.sv
// Shared CABAC constants used across the entropy-coding pipeline.
package cabac_pkg;

   // Width of one packed syntax-element word from the SE generator.
   localparam int CABAC_SE_W = 76;

endpackage

// File: rtl/cabac_fifo_mem.sv
// 1-write/1-read register array: synchronous write, asynchronous read.
// Kept separate so it can be replaced by a two-port SRAM wrapper for deep FIFOs.
module cabac_fifo_mem #(
   parameter int DATA_W = 76,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_reg [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   assign rdata = mem_reg[raddr];

endmodule

// File: rtl/cabac_sync_fifo.sv
// First-word-fall-through synchronous FIFO between the syntax-element
// generator and the binarizer, with occupancy flags, flush and sticky errors.
module cabac_sync_fifo
   import cabac_pkg::*;
#(
   parameter  int DATA_W    = CABAC_SE_W,
   parameter  int DEPTH     = 8,
   parameter  int AFULL_TH  = DEPTH - 2,
   parameter  int AEMPTY_TH = 1,
   localparam int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              full_o,
   output logic              almost_full_o,
   input  logic              rd_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              almost_empty_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              ovf_o,
   output logic              udf_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  wptr_reg, wptr_next;
   logic [PTR_W-1:0]  rptr_reg, rptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              ovf_reg, ovf_next;
   logic              udf_reg, udf_next;
   logic              push, pop;
   logic [DATA_W-1:0] head_data;

   // A write while full is dropped even if a pop frees a slot in the same cycle.
   assign push = wr_i & ~full_o;
   assign pop  = rd_i & valid_o;

   always_comb begin
      wptr_next  = wptr_reg;
      rptr_next  = rptr_reg;
      count_next = count_reg;
      ovf_next   = ovf_reg | (wr_i & full_o);
      udf_next   = udf_reg | (rd_i & ~valid_o);
      if (flush_i) begin
         wptr_next  = '0;
         rptr_next  = '0;
         count_next = '0;
         ovf_next   = 1'b0;
         udf_next   = 1'b0;
      end else begin
         if (push) begin
            wptr_next = wptr_reg + 1'b1;
         end
         if (pop) begin
            rptr_next = rptr_reg + 1'b1;
         end
         count_next = count_reg + {{(CNT_W-1){1'b0}}, push}
                                - {{(CNT_W-1){1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         udf_reg   <= 1'b0;
      end else begin
         wptr_reg  <= wptr_next;
         rptr_reg  <= rptr_next;
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         udf_reg   <= udf_next;
      end
   end

   cabac_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push & ~flush_i),
      .waddr (wptr_reg),
      .wdata (data_i),
      .raddr (rptr_reg),
      .rdata (head_data)
   );

   assign full_o         = (count_reg == CNT_W'(DEPTH));
   assign valid_o        = (count_reg != '0);
   assign almost_full_o  = (count_reg >= CNT_W'(AFULL_TH));
   assign almost_empty_o = (count_reg <= CNT_W'(AEMPTY_TH));
   assign count_o        = count_reg;
   assign data_o         = valid_o ? head_data : '0;
   assign ovf_o          = ovf_reg;
   assign udf_o          = udf_reg;

endmodule

// File: tb/tb_cabac_sync_fifo.sv
// Scoreboard bench: directed vectors on a default 8x76 FIFO, plus random
// traffic on 2-deep and 64-deep 32-bit instances checked against queue models.
module tb_cabac_sync_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_i = 1'b0;
   logic        wr_i = 1'b0;
   logic        rd_i = 1'b0;
   logic [75:0] data_i = '0;
   logic        full_o, almost_full_o, valid_o, almost_empty_o, ovf_o, udf_o;
   logic [75:0] data_o;
   logic [3:0]  count_o;

   logic        s_wr = 1'b0;
   logic        s_rd = 1'b0;
   logic        s_flush = 1'b0;
   logic [31:0] s_data = '0;
   logic        d2_full, d2_afull, d2_valid, d2_aempty, d2_ovf, d2_udf;
   logic [31:0] d2_data;
   logic [1:0]  d2_count;
   logic        d64_full, d64_afull, d64_valid, d64_aempty, d64_ovf, d64_udf;
   logic [31:0] d64_data;
   logic [6:0]  d64_count;

   int n_checks = 0;
   int n_fail   = 0;
   int mcount   = 0;
   logic [75:0] exp_q [$];
   logic [31:0] q2 [$];
   logic [31:0] q64 [$];

   always #5 clk = ~clk;

   cabac_sync_fifo u_dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .wr_i(wr_i), .data_i(data_i),
      .full_o(full_o), .almost_full_o(almost_full_o), .rd_i(rd_i), .data_o(data_o),
      .valid_o(valid_o), .almost_empty_o(almost_empty_o), .count_o(count_o),
      .ovf_o(ovf_o), .udf_o(udf_o)
   );

   cabac_sync_fifo #(.DATA_W(32), .DEPTH(2)) u_d2 (
      .clk(clk), .rst(rst), .flush_i(s_flush), .wr_i(s_wr), .data_i(s_data),
      .full_o(d2_full), .almost_full_o(d2_afull), .rd_i(s_rd), .data_o(d2_data),
      .valid_o(d2_valid), .almost_empty_o(d2_aempty), .count_o(d2_count),
      .ovf_o(d2_ovf), .udf_o(d2_udf)
   );

   cabac_sync_fifo #(.DATA_W(32), .DEPTH(64)) u_d64 (
      .clk(clk), .rst(rst), .flush_i(s_flush), .wr_i(s_wr), .data_i(s_data),
      .full_o(d64_full), .almost_full_o(d64_afull), .rd_i(s_rd), .data_o(d64_data),
      .valid_o(d64_valid), .almost_empty_o(d64_aempty), .count_o(d64_count),
      .ovf_o(d64_ovf), .udf_o(d64_udf)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the bench's own occupancy model decides what is accepted.
   task automatic cycle(input bit wr, input bit rd, input bit fl, input logic [75:0] d);
      bit push, pop;
      wr_i = wr; rd_i = rd; flush_i = fl; data_i = d;
      if (fl) begin
         exp_q.delete();
         mcount = 0;
      end else begin
         push = wr && (mcount != 8);
         pop  = rd && (mcount != 0);
         if (push) exp_q.push_back(d);
         mcount = mcount + int'(push) - int'(pop);
      end
      @(posedge clk); #1;
      wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0;
      exp_q.delete();
      mcount = 0;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic status(input string tag);
      chk({tag, "_count"},  128'(count_o),        128'(mcount));
      chk({tag, "_valid"},  128'(valid_o),        128'(mcount != 0));
      chk({tag, "_full"},   128'(full_o),         128'(mcount == 8));
      chk({tag, "_afull"},  128'(almost_full_o),  128'(mcount >= 6));
      chk({tag, "_aempty"}, 128'(almost_empty_o), 128'(mcount <= 1));
   endtask

   // Monitor: a handshake seen between edges is the pop the next edge performs.
   always @(negedge clk) begin
      if (!rst && !flush_i && rd_i && valid_o) begin
         if (exp_q.size() == 0) begin
            chk("main_unexpected_pop", 128'(data_o), 128'hDEAD);
         end else begin
            chk("main_data", 128'(data_o), 128'(exp_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin : mon_d2
      int n;
      if (rst) begin
         q2.delete();
      end else begin
         n = q2.size();
         chk("d2_count", 128'(d2_count), 128'(n));
         chk("d2_valid", 128'(d2_valid), 128'(n != 0));
         chk("d2_full",  128'(d2_full),  128'(n == 2));
         if (s_rd && n != 0) chk("d2_data", 128'(d2_data), 128'(q2.pop_front()));
         if (s_wr && n != 2) q2.push_back(s_data);
      end
   end

   always @(negedge clk) begin : mon_d64
      int n;
      if (rst) begin
         q64.delete();
      end else begin
         n = q64.size();
         chk("d64_count", 128'(d64_count), 128'(n));
         chk("d64_valid", 128'(d64_valid), 128'(n != 0));
         chk("d64_full",  128'(d64_full),  128'(n == 64));
         if (s_rd && n != 0) chk("d64_data", 128'(d64_data), 128'(q64.pop_front()));
         if (s_wr && n != 64) q64.push_back(s_data);
      end
   end

   initial begin
      do_reset(2);
      status("reset");
      chk("reset_data", 128'(data_o), 128'(0));
      chk("reset_ovf", 128'(ovf_o), 128'(0));
      chk("reset_udf", 128'(udf_o), 128'(0));

      // Fill 1..8, then a dropped write while full.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 76'(i));
         status($sformatf("fill%0d", i));
      end
      cycle(1'b1, 1'b0, 1'b0, 76'hAA);
      status("ovf");
      chk("ovf_set", 128'(ovf_o), 128'(1));
      cycle(1'b0, 1'b0, 1'b0, 76'h0);
      chk("ovf_sticky", 128'(ovf_o), 128'(1));

      // Full with wr and rd: pop only.
      cycle(1'b1, 1'b1, 1'b0, 76'hBB);
      status("full_wr_rd");
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 76'h0);
         status($sformatf("drain%0d", i));
      end
      chk("empty_data", 128'(data_o), 128'(0));

      // Underflow, then empty with wr and rd: push only.
      cycle(1'b0, 1'b1, 1'b0, 76'h0);
      chk("udf_set", 128'(udf_o), 128'(1));
      chk("udf_data", 128'(data_o), 128'(0));
      cycle(1'b1, 1'b1, 1'b0, 76'h55);
      status("empty_wr_rd");
      chk("fwft_head", 128'(data_o), 128'h55);

      // Flush beats simultaneous push and pop.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 76'(8'h56 + i));
      status("preflush");
      chk("preflush_ovf", 128'(ovf_o), 128'(1));
      cycle(1'b1, 1'b1, 1'b1, 76'h99);
      status("flush");
      chk("flush_ovf", 128'(ovf_o), 128'(0));
      chk("flush_udf", 128'(udf_o), 128'(0));
      chk("flush_data", 128'(data_o), 128'(0));

      // Steady push+pop across pointer wrap.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 76'(12'h100 + i));
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 76'(12'h200 + i));
         chk("wrap_count", 128'(count_o), 128'(3));
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 76'h0);
      status("wrap_done");

      // Reset mid-stream with 5 entries.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 76'(12'h300 + i));
      cycle(1'b0, 1'b1, 1'b0, 76'h0);
      do_reset(2);
      status("midreset");
      chk("midreset_data", 128'(data_o), 128'(0));
      chk("midreset_ovf", 128'(ovf_o), 128'(0));
      chk("midreset_udf", 128'(udf_o), 128'(0));

      // Random traffic on the 2-deep and 64-deep instances.
      for (int i = 0; i < 400; i++) begin
         if (i < 200) begin
            s_wr = ($urandom_range(0, 3) != 0);
            s_rd = ($urandom_range(0, 3) == 0);
         end else begin
            s_wr = ($urandom_range(0, 3) == 0);
            s_rd = ($urandom_range(0, 3) != 0);
         end
         s_data = $urandom;
         @(posedge clk); #1;
      end
      s_wr = 1'b0;
      s_rd = 1'b1;
      repeat (70) @(posedge clk);
      #1 s_rd = 1'b0;
      @(negedge clk);
      chk("main_queue_empty", 128'(exp_q.size()), 128'(0));
      chk("d2_queue_empty", 128'(q2.size()), 128'(0));
      chk("d64_queue_empty", 128'(q64.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
